// File: rtl/vezerles_pkg.sv
// Shared types and helpers for the programmable control-logic block.
// The flattened-table accessor supports the largest legal table (256 x 16 bits).
package vezerles_pkg;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    STABLE  = 2'd1,
    REFRESH = 2'd2
  } state_t;

  localparam logic [15:0] DEF_TABLE_INIT = 16'hFA95;
  localparam int          MAX_FLAT       = 4096;
  localparam int          MAX_OUT        = 16;

  // Returns entry idx of a flattened table; bits above n_out read as zero.
  function automatic logic [MAX_OUT-1:0] table_entry(
    input logic [MAX_FLAT-1:0] flat,
    input int                  idx,
    input int                  n_out
  );
    logic [MAX_OUT-1:0] e;
    e = '0;
    for (int b = 0; b < MAX_OUT; b++) begin
      if (b < n_out) e[b] = flat[idx*n_out + b];
    end
    return e;
  endfunction

endpackage

// File: rtl/vezerles_prog_bemenet_szuro.sv
// Two-flop input synchroniser plus debounce counter. Produces the candidate
// input vector, a change indication and a commit strobe once cand has held.
module bemenet_szuro
  import vezerles_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int STABLE_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_a,
  input  logic            track,
  input  logic            count_en,
  output logic [N_IN-1:0] cand,
  output logic            change,
  output logic            commit
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [N_IN-1:0] sync1_reg;
  logic [N_IN-1:0] syn_reg;
  logic [N_IN-1:0] cand_reg;
  logic [CW-1:0]   cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      syn_reg   <= '0;
    end else begin
      sync1_reg <= in_a;
      syn_reg   <= sync1_reg;
    end
  end

  assign change = track && (syn_reg != cand_reg);
  assign commit = count_en && (syn_reg == cand_reg) &&
                  (cnt_reg == CW'(STABLE_CYC - 1));

  // cnt only advances while settling; any change restarts the hold window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg <= '0;
      cnt_reg  <= '0;
    end else if (change) begin
      cand_reg <= syn_reg;
      cnt_reg  <= '0;
    end else if (count_en && !commit) begin
      cnt_reg  <= cnt_reg + 1'b1;
    end
  end

  assign cand = cand_reg;

endmodule

// File: rtl/vezerles_prog.sv
// Programmable control logic: debounced inputs index a writable truth table
// whose selected entry drives registered outputs with a change pulse.
module vezerles_prog
  import vezerles_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int N_OUT      = 2,
  parameter int STABLE_CYC = 4,
  parameter logic [(2**N_IN)*N_OUT-1:0] TABLE_INIT = DEF_TABLE_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in_a,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  output logic [N_OUT-1:0] q,
  output logic             q_upd,
  output logic             stable
);

  localparam int                  DEPTH    = 2**N_IN;
  localparam logic [MAX_FLAT-1:0] INIT_EXT = MAX_FLAT'(TABLE_INIT);

  state_t           state_reg, state_next;
  logic [N_IN-1:0]  cand;
  logic             change;
  logic             commit;
  logic             load;
  logic [N_OUT-1:0] sel;
  logic [N_OUT-1:0] q_reg;
  logic             q_upd_reg;
  logic [N_OUT-1:0] tbl_reg  [DEPTH];
  logic [N_OUT-1:0] init_ent [DEPTH];

  bemenet_szuro #(
    .N_IN       (N_IN),
    .STABLE_CYC (STABLE_CYC)
  ) u_szuro (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_a     (in_a),
    .track    (state_reg != REFRESH),
    .count_en (state_reg == SETTLE),
    .cand     (cand),
    .change   (change),
    .commit   (commit)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
      assign init_ent[gi] = N_OUT'(table_entry(INIT_EXT, gi, N_OUT));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_reg[i] <= init_ent[i];
    end else if (cfg_we) begin
      tbl_reg[cfg_addr] <= cfg_data;
    end
  end

  // Write-first: a write landing on the same edge as a load wins.
  assign sel = (cfg_we && (cfg_addr == cand)) ? cfg_data : tbl_reg[cand];

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      SETTLE: begin
        if (commit) begin
          load       = 1'b1;
          state_next = STABLE;
        end
      end
      STABLE: begin
        if (change)                              state_next = SETTLE;
        else if (cfg_we && (cfg_addr == cand))   state_next = REFRESH;
      end
      REFRESH: begin
        load       = 1'b1;
        state_next = STABLE;
      end
      default: state_next = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SETTLE;
      q_reg     <= '0;
      q_upd_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_upd_reg <= load && (sel != q_reg);
      if (load) q_reg <= sel;
    end
  end

  assign q      = q_reg;
  assign q_upd  = q_upd_reg;
  assign stable = (state_reg == STABLE);

endmodule

// File: tb/tb_vezerles_prog.sv
// Directed bench for vezerles_prog: expected q values are queued when stimulus
// is applied and checked whenever the DUT pulses q_upd.
module tb_vezerles_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_a = '0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [1:0] cfg_data = '0;
  logic [1:0] q;
  logic       q_upd;
  logic       stable;

  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];

  vezerles_prog dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_a     (in_a),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .q        (q),
    .q_upd    (q_upd),
    .stable   (stable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every q_upd pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && q_upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_q_upd", {14'd0, q}, 16'hFFFF);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("q_upd_value", {14'd0, q}, {14'd0, e});
        $display("txn: q_upd q=%b expected=%b", q, e);
      end
    end
  end

  task automatic wait_stable(input string tag, input int limit);
    int n;
    n = 0;
    while (stable !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {15'd0, stable}, 16'd1);
  endtask

  initial begin
    bit saw_low;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_q", {14'd0, q}, 16'd0);
    check("rst_stable", {15'd0, stable}, 16'd0);
    check("rst_q_upd", {15'd0, q_upd}, 16'd0);

    // First commit of entry 0 after reset
    exp_q.push_back(2'b01);
    rst_n = 1'b1;
    wait_stable("init_stable", 20);
    check("init_q", {14'd0, q}, 16'h1);

    // 000 -> 011: q must hold through edge 6 and change at edge 7
    @(negedge clk);
    exp_q.push_back(2'b10);
    in_a = 3'b011;
    repeat (6) @(negedge clk);
    check("lat_before_q", {14'd0, q}, 16'h1);
    @(negedge clk);
    check("lat_at7_q", {14'd0, q}, 16'h2);
    check("lat_at7_upd", {15'd0, q_upd}, 16'd1);
    check("lat_at7_stable", {15'd0, stable}, 16'd1);

    // 011 -> 100: same output, no pulse expected
    in_a = 3'b100;
    repeat (3) @(negedge clk);
    wait_stable("same_out_stable", 20);
    check("same_out_q", {14'd0, q}, 16'h2);

    // Two-cycle glitch on in_a[0]
    in_a = 3'b101;
    repeat (2) @(negedge clk);
    in_a = 3'b100;
    saw_low = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stable === 1'b0) saw_low = 1'b1;
    end
    check("glitch_dropped", {15'd0, saw_low}, 16'd1);
    wait_stable("glitch_stable", 20);
    check("glitch_q", {14'd0, q}, 16'h2);

    // Move to cand=110 (entry 11), then rewrite it to 00 while stable
    exp_q.push_back(2'b11);
    in_a = 3'b110;
    repeat (3) @(negedge clk);
    wait_stable("c110_stable", 20);
    check("c110_q", {14'd0, q}, 16'h3);
    exp_q.push_back(2'b00);
    cfg_we = 1'b1; cfg_addr = 3'b110; cfg_data = 2'b00;
    @(negedge clk);
    cfg_we = 1'b0;
    check("refresh_stable_low", {15'd0, stable}, 16'd0);
    check("refresh_q_old", {14'd0, q}, 16'h3);
    @(negedge clk);
    check("refresh_q", {14'd0, q}, 16'h0);
    check("refresh_upd", {15'd0, q_upd}, 16'd1);
    check("refresh_stable", {15'd0, stable}, 16'd1);

    // Write on the commit edge for cand=101: bypass value must win
    exp_q.push_back(2'b01);
    in_a = 3'b101;
    repeat (6) @(negedge clk);
    check("bypass_pre_q", {14'd0, q}, 16'h0);
    cfg_we = 1'b1; cfg_addr = 3'b101; cfg_data = 2'b01;
    @(negedge clk);
    cfg_we = 1'b0;
    check("bypass_q", {14'd0, q}, 16'h1);
    check("bypass_stable", {15'd0, stable}, 16'd1);

    // Overwrite entry 3, start settling on 011, then reset mid-SETTLE
    cfg_we = 1'b1; cfg_addr = 3'b011; cfg_data = 2'b00;
    @(negedge clk);
    cfg_we = 1'b0;
    in_a = 3'b011;
    repeat (4) @(negedge clk);
    check("pre_rst_stable", {15'd0, stable}, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", {14'd0, q}, 16'h0);
    check("midrst_stable", {15'd0, stable}, 16'd0);
    @(negedge clk);
    exp_q.push_back(2'b10);
    rst_n = 1'b1;
    wait_stable("post_rst_stable", 20);
    check("post_rst_q", {14'd0, q}, 16'h2);

    repeat (3) @(negedge clk);
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
